// File: rtl/l2_cache_pkg.sv
// Shared encodings for the L2 MESI sequencer, its line array and the cache_Mesi block.
package l2_cache_pkg;

  typedef enum logic [1:0] {
    MESI_M = 2'd0,
    MESI_E = 2'd1,
    MESI_S = 2'd2,
    MESI_I = 2'd3
  } mesi_t;

  typedef enum logic [3:0] {
    CMD_RD      = 4'd0,
    CMD_WR      = 4'd1,
    CMD_IRD     = 4'd2,
    CMD_SNP_INV = 4'd3,
    CMD_SNP_RD  = 4'd4,
    CMD_SNP_WR  = 4'd5,
    CMD_SNP_RFO = 4'd6,
    CMD_CLEAR   = 4'd8,
    CMD_PRINT   = 4'd9
  } cmd_t;

  typedef enum logic [1:0] {
    SNP_NOHIT = 2'd0,
    SNP_HIT   = 2'd1,
    SNP_HITM  = 2'd2
  } snp_t;

  typedef enum logic [1:0] {
    BUS_READ       = 2'd0,
    BUS_WRITEBACK  = 2'd1,
    BUS_INVALIDATE = 2'd2,
    BUS_RFO        = 2'd3
  } bus_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WB,
    ST_BUS,
    ST_UPDATE
  } fsm_t;

  function automatic logic is_local(input logic [3:0] c);
    return c <= CMD_IRD;
  endfunction

  function automatic logic is_snoop(input logic [3:0] c);
    return (c >= CMD_SNP_INV) && (c <= CMD_SNP_RFO);
  endfunction

endpackage

// File: rtl/l2_line_array.sv
// Direct-mapped tag/state storage: one combinational read port, one write port, invalidate-all.
module l2_line_array
  import l2_cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned TAG_W      = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [1:0]            rd_state,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [1:0]            wr_state,
  input  logic                  inv_all
);

  localparam int unsigned NUM_LINES = 2 ** INDEX_BITS;

  logic [TAG_W-1:0] tag_q [NUM_LINES];
  logic [1:0]       st_q  [NUM_LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        tag_q[i] <= '0;
        st_q[i]  <= MESI_I;
      end
    end else if (inv_all) begin
      // Tags are left alone; an I line never hits regardless of its tag.
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        st_q[i] <= MESI_I;
      end
    end else if (we) begin
      tag_q[wr_index] <= wr_tag;
      st_q[wr_index]  <= wr_state;
    end
  end

  always_comb begin
    rd_tag   = tag_q[rd_index];
    rd_state = st_q[rd_index];
  end

endmodule

// File: rtl/l2_mesi_sequencer.sv
// Command sequencer around the cache_Mesi next-state block: lookup, bus ops, state write-back.
module l2_mesi_sequencer
  import l2_cache_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned INDEX_BITS  = 4,
  parameter int unsigned OFFSET_BITS = 6,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd,
  input  logic [ADDR_W-1:0] addr,
  output logic              bus_req,
  output logic [1:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack,
  input  logic [1:0]        bus_snoop_resp,
  output logic [1:0]        snoop_resp_out,
  output logic [1:0]        mesi_present_state,
  output logic [3:0]        mesi_command,
  output logic [1:0]        mesi_snoop_resp,
  input  logic [1:0]        mesi_result_state,
  output logic              done,
  output logic              hit,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int unsigned TAG_W = ADDR_W - INDEX_BITS - OFFSET_BITS;

  fsm_t state_q, state_d;

  logic [3:0]            cmd_r;
  logic [TAG_W-1:0]      tag_r;
  logic [INDEX_BITS-1:0] idx_r;
  logic [1:0]            fill_op_r;
  logic                  hit_r;
  logic [1:0]            snp_out_r;
  logic [1:0]            mesi_ps_r;
  logic [1:0]            mesi_sr_r;
  logic [1:0]            bus_op_r;
  logic [ADDR_W-1:0]     bus_addr_r;
  logic [CNT_W-1:0]      hit_cnt_r;
  logic [CNT_W-1:0]      miss_cnt_r;

  logic [TAG_W-1:0]      rd_tag;
  logic [1:0]            rd_state;
  logic                  arr_we;
  logic                  arr_inv_all;

  logic                  loc_cmd;
  logic                  snp_cmd;
  logic                  lk_hit;
  logic                  need_wb;
  logic                  need_bus;
  logic [1:0]            fill_op;
  logic [1:0]            own_resp;
  logic [ADDR_W-1:0]     req_line;
  logic [ADDR_W-1:0]     wb_line;

  logic                  unused_ok;
  assign unused_ok = ^addr[OFFSET_BITS-1:0];

  l2_line_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_lines (
    .clk      (clk),
    .rst      (rst),
    .rd_index (idx_r),
    .rd_tag   (rd_tag),
    .rd_state (rd_state),
    .we       (arr_we),
    .wr_index (idx_r),
    .wr_tag   (tag_r),
    .wr_state (mesi_result_state),
    .inv_all  (arr_inv_all)
  );

  // Lookup decode; only meaningful while in LOOKUP, the array read is combinational.
  always_comb begin
    loc_cmd  = is_local(cmd_r);
    snp_cmd  = is_snoop(cmd_r);
    lk_hit   = (rd_tag == tag_r) && (rd_state != MESI_I);
    req_line = {tag_r, idx_r, {OFFSET_BITS{1'b0}}};
    wb_line  = {rd_tag, idx_r, {OFFSET_BITS{1'b0}}};
    need_bus = !lk_hit || ((cmd_r == CMD_WR) && (rd_state == MESI_S));
    fill_op  = BUS_READ;
    if (!lk_hit) begin
      fill_op = (cmd_r == CMD_WR) ? BUS_RFO : BUS_READ;
    end else if (cmd_r == CMD_WR) begin
      fill_op = BUS_INVALIDATE;
    end
    own_resp = SNP_NOHIT;
    if (lk_hit) begin
      own_resp = (rd_state == MESI_M) ? SNP_HITM : SNP_HIT;
    end
    need_wb = 1'b0;
    if (loc_cmd) begin
      need_wb = !lk_hit && (rd_state == MESI_M);
    end else if (snp_cmd) begin
      need_wb = lk_hit && (rd_state == MESI_M) && (cmd_r != CMD_SNP_INV);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cmd_valid) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        if (need_wb) begin
          state_d = ST_WB;
        end else if (loc_cmd && need_bus) begin
          state_d = ST_BUS;
        end else begin
          state_d = ST_UPDATE;
        end
      end
      ST_WB:     if (bus_ack) state_d = loc_cmd ? ST_BUS : ST_UPDATE;
      ST_BUS:    if (bus_ack) state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = (state_q == ST_IDLE);
    bus_req     = (state_q == ST_WB) || (state_q == ST_BUS);
    done        = (state_q == ST_UPDATE);
    arr_we      = (state_q == ST_UPDATE) && (loc_cmd || (snp_cmd && hit_r));
    arr_inv_all = (state_q == ST_UPDATE) && (cmd_r == CMD_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_r      <= CMD_CLEAR;
      tag_r      <= '0;
      idx_r      <= '0;
      fill_op_r  <= BUS_READ;
      hit_r      <= 1'b0;
      snp_out_r  <= SNP_NOHIT;
      mesi_ps_r  <= MESI_I;
      mesi_sr_r  <= SNP_NOHIT;
      bus_op_r   <= BUS_READ;
      bus_addr_r <= '0;
      hit_cnt_r  <= '0;
      miss_cnt_r <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_r <= cmd;
            tag_r <= addr[ADDR_W-1 -: TAG_W];
            idx_r <= addr[OFFSET_BITS +: INDEX_BITS];
          end
        end
        ST_LOOKUP: begin
          hit_r     <= (loc_cmd || snp_cmd) && lk_hit;
          snp_out_r <= snp_cmd ? own_resp : SNP_NOHIT;
          mesi_ps_r <= lk_hit ? rd_state : MESI_I;
          mesi_sr_r <= snp_cmd ? own_resp : SNP_NOHIT;
          fill_op_r <= fill_op;
          // Bus op/address are loaded once here so they stay stable until ack.
          if (need_wb) begin
            bus_op_r   <= BUS_WRITEBACK;
            bus_addr_r <= wb_line;
          end else begin
            bus_op_r   <= fill_op;
            bus_addr_r <= req_line;
          end
        end
        ST_WB: begin
          if (bus_ack) begin
            bus_op_r   <= fill_op_r;
            bus_addr_r <= req_line;
          end
        end
        ST_BUS: begin
          if (bus_ack) begin
            mesi_sr_r <= bus_snoop_resp;
          end
        end
        ST_UPDATE: begin
          if (loc_cmd) begin
            if (hit_r) begin
              hit_cnt_r <= hit_cnt_r + 1'b1;
            end else begin
              miss_cnt_r <= miss_cnt_r + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus_op             = bus_op_r;
    bus_addr           = bus_addr_r;
    hit                = hit_r;
    snoop_resp_out     = snp_out_r;
    mesi_present_state = mesi_ps_r;
    mesi_command       = cmd_r;
    mesi_snoop_resp    = mesi_sr_r;
    hit_count          = hit_cnt_r;
    miss_count         = miss_cnt_r;
  end

endmodule

// File: tb/tb_l2_mesi_sequencer.sv
// Directed scoreboard bench for l2_mesi_sequencer with a behavioural cache_Mesi next-state model.
module tb_l2_mesi_sequencer;

  localparam logic [1:0] M = 2'd0, E = 2'd1, S = 2'd2, I = 2'd3;
  localparam logic [1:0] NOHIT = 2'd0, HIT = 2'd1, HITM = 2'd2;
  localparam logic [1:0] RD_OP = 2'd0, WB_OP = 2'd1, INV_OP = 2'd2, RFO_OP = 2'd3;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
  } bus_exp_t;

  typedef struct {
    logic       hit;
    logic [1:0] sresp;
    logic [1:0] ps;
    logic [1:0] msr;
    logic [3:0] c;
    int         lat;
  } done_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd;
  logic [31:0] addr;
  logic        bus_req;
  logic [1:0]  bus_op;
  logic [31:0] bus_addr;
  logic        bus_ack;
  logic [1:0]  bus_snoop_resp;
  logic [1:0]  snoop_resp_out;
  logic [1:0]  mesi_present_state;
  logic [3:0]  mesi_command;
  logic [1:0]  mesi_snoop_resp;
  logic [1:0]  mesi_result_state;
  logic        done;
  logic        hit;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int tests = 0;
  int fails = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];

  l2_mesi_sequencer #(
    .ADDR_W      (32),
    .INDEX_BITS  (4),
    .OFFSET_BITS (6),
    .CNT_W       (32)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd                (cmd),
    .addr               (addr),
    .bus_req            (bus_req),
    .bus_op             (bus_op),
    .bus_addr           (bus_addr),
    .bus_ack            (bus_ack),
    .bus_snoop_resp     (bus_snoop_resp),
    .snoop_resp_out     (snoop_resp_out),
    .mesi_present_state (mesi_present_state),
    .mesi_command       (mesi_command),
    .mesi_snoop_resp    (mesi_snoop_resp),
    .mesi_result_state  (mesi_result_state),
    .done               (done),
    .hit                (hit),
    .hit_count          (hit_count),
    .miss_count         (miss_count)
  );

  always #5 clk = ~clk;

  // External cache_Mesi next-state behaviour.
  function automatic logic [1:0] mesi_next(input logic [1:0] ps, input logic [3:0] c,
                                           input logic [1:0] sr);
    case (c)
      4'd0, 4'd2: return (ps == I) ? ((sr == NOHIT) ? E : S) : ps;
      4'd1:       return M;
      4'd3, 4'd6: return I;
      4'd4:       return (ps == I) ? I : S;
      4'd8:       return I;
      default:    return ps;
    endcase
  endfunction

  always_comb mesi_result_state = mesi_next(mesi_present_state, mesi_command, mesi_snoop_resp);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_counters();
    check("hit_count", hit_count, exp_hits);
    check("miss_count", miss_count, exp_miss);
  endtask

  task automatic do_cmd(input logic [3:0] c, input logic [31:0] a, input int dly,
                        input logic [1:0] resp, input logic ehit, input logic [1:0] esr,
                        input logic [1:0] eps, input logic [1:0] emsr, input int nops,
                        input logic [1:0] op0, input logic [31:0] a0,
                        input logic [1:0] op1, input logic [31:0] a1);
    done_exp_t de;
    done_exp_t dg;
    bus_exp_t  cur;
    int        w;
    int        cyc;
    int        opcyc;
    logic      got_done;
    de.hit = ehit; de.sresp = esr; de.ps = eps; de.msr = emsr; de.c = c;
    de.lat = 2 + nops * (dly + 1);
    done_q.push_back(de);
    if (nops > 0) bus_q.push_back('{op: op0, a: a0});
    if (nops > 1) bus_q.push_back('{op: op1, a: a1});
    if (c <= 4'd2) begin
      if (ehit) exp_hits++;
      else exp_miss++;
    end
    @(negedge clk);
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd = c;
    addr = a;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cyc = 0;
    opcyc = 0;
    got_done = 1'b0;
    cur = '{op: 2'd0, a: 32'd0};
    while (!got_done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      bus_ack = 1'b0;
      bus_snoop_resp = NOHIT;
      if (bus_req) begin
        if (opcyc == 0) begin
          if (bus_q.size() == 0) check("unexpected_bus_req", bus_req, 0);
          else cur = bus_q.pop_front();
        end
        check("bus_op", bus_op, cur.op);
        check("bus_addr", bus_addr, cur.a);
        if (opcyc == dly) begin
          bus_ack = 1'b1;
          bus_snoop_resp = resp;
          opcyc = 0;
        end else begin
          opcyc++;
        end
      end
      if (done) begin
        got_done = 1'b1;
        dg = done_q.pop_front();
        check("hit", hit, dg.hit);
        check("snoop_resp_out", snoop_resp_out, dg.sresp);
        check("mesi_present_state", mesi_present_state, dg.ps);
        check("mesi_snoop_resp", mesi_snoop_resp, dg.msr);
        check("mesi_command", mesi_command, dg.c);
        check("latency", cyc, dg.lat);
      end
    end
    bus_ack = 1'b0;
    bus_snoop_resp = NOHIT;
    check("done_seen", got_done, 1);
    check("bus_ops_outstanding", bus_q.size(), 0);
    bus_q.delete();
    @(negedge clk);
    check("bus_req_after_done", bus_req, 0);
    check_counters();
  endtask

  initial begin
    int w;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd = 4'd0;
    addr = '0;
    bus_ack = 1'b0;
    bus_snoop_resp = NOHIT;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_bus_req", bus_req, 0);
    check("rst_done", done, 0);
    check("rst_hit", hit, 0);
    check("rst_snoop_resp_out", snoop_resp_out, NOHIT);
    check("rst_mesi_ps", mesi_present_state, I);
    check("rst_mesi_cmd", mesi_command, 4'd8);
    check("rst_mesi_sr", mesi_snoop_resp, NOHIT);
    check_counters();

    //     cmd    addr          dly resp   hit  sresp  ps  msr   n  op0     a0            op1    a1
    do_cmd(4'd0, 32'h0000_1040, 2, NOHIT, 0, NOHIT, I, NOHIT, 1, RD_OP,  32'h0000_1040, RD_OP, 0);
    do_cmd(4'd0, 32'h0000_1040, 0, NOHIT, 1, NOHIT, E, NOHIT, 0, RD_OP,  0,             RD_OP, 0);
    do_cmd(4'd0, 32'h0000_2080, 1, HIT,   0, NOHIT, I, HIT,   1, RD_OP,  32'h0000_2080, RD_OP, 0);
    do_cmd(4'd1, 32'h0000_2080, 3, HIT,   1, NOHIT, S, HIT,   1, INV_OP, 32'h0000_2080, RD_OP, 0);
    do_cmd(4'd2, 32'h0000_2084, 0, NOHIT, 1, NOHIT, M, NOHIT, 0, RD_OP,  0,             RD_OP, 0);
    do_cmd(4'd1, 32'h0000_1040, 0, NOHIT, 1, NOHIT, E, NOHIT, 0, RD_OP,  0,             RD_OP, 0);
    do_cmd(4'd0, 32'h0002_1040, 1, NOHIT, 0, NOHIT, I, NOHIT, 2, WB_OP,  32'h0000_1040, RD_OP, 32'h0002_1040);
    do_cmd(4'd0, 32'h0002_1040, 0, NOHIT, 1, NOHIT, E, NOHIT, 0, RD_OP,  0,             RD_OP, 0);
    do_cmd(4'd1, 32'h0000_1040, 0, NOHIT, 0, NOHIT, I, NOHIT, 1, RFO_OP, 32'h0000_1040, RD_OP, 0);
    do_cmd(4'd4, 32'h0000_1040, 1, NOHIT, 1, HITM,  M, HITM,  1, WB_OP,  32'h0000_1040, RD_OP, 0);
    do_cmd(4'd0, 32'h0000_1040, 0, NOHIT, 1, NOHIT, S, NOHIT, 0, RD_OP,  0,             RD_OP, 0);
    do_cmd(4'd3, 32'h0000_5000, 0, NOHIT, 0, NOHIT, I, NOHIT, 0, RD_OP,  0,             RD_OP, 0);
    do_cmd(4'd6, 32'h0000_1040, 0, NOHIT, 1, HIT,   S, HIT,   0, RD_OP,  0,             RD_OP, 0);
    do_cmd(4'd0, 32'h0000_1040, 0, HITM,  0, NOHIT, I, HITM,  1, RD_OP,  32'h0000_1040, RD_OP, 0);
    do_cmd(4'd9, 32'h0000_5000, 0, NOHIT, 0, NOHIT, I, NOHIT, 0, RD_OP,  0,             RD_OP, 0);
    do_cmd(4'd0, 32'h0000_2080, 0, NOHIT, 1, NOHIT, M, NOHIT, 0, RD_OP,  0,             RD_OP, 0);
    do_cmd(4'd8, 32'h0000_5000, 0, NOHIT, 0, NOHIT, I, NOHIT, 0, RD_OP,  0,             RD_OP, 0);
    do_cmd(4'd0, 32'h0000_2080, 0, NOHIT, 0, NOHIT, I, NOHIT, 1, RD_OP,  32'h0000_2080, RD_OP, 0);

    // Reset while a bus op waits for ack.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd = 4'd0;
    addr = 32'h0000_3000;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    w = 0;
    @(negedge clk);
    while (!bus_req && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("midop_bus_req", bus_req, 1);
    check("midop_bus_op", bus_op, RD_OP);
    check("midop_bus_addr", bus_addr, 32'h0000_3000);
    @(negedge clk);
    check("midop_bus_held", bus_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_hits = 0;
    exp_miss = 0;
    check("midrst_bus_req", bus_req, 0);
    check("midrst_done", done, 0);
    check("midrst_hit", hit, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_mesi_ps", mesi_present_state, I);
    check("midrst_mesi_cmd", mesi_command, 4'd8);
    check("midrst_mesi_sr", mesi_snoop_resp, NOHIT);
    check_counters();

    do_cmd(4'd8, 32'h0000_0000, 0, NOHIT, 0, NOHIT, I, NOHIT, 0, RD_OP, 0,             RD_OP, 0);
    do_cmd(4'd0, 32'h0000_1040, 0, NOHIT, 0, NOHIT, I, NOHIT, 1, RD_OP, 32'h0000_1040, RD_OP, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/l2_mesi_sequencer.md
Name: l2_mesi_sequencer

Overview:
Control stage directly upstream and downstream of the L2 MESI next-state block (cache_Mesi). Accepts trace/snoop commands and addresses, looks up a direct-mapped tag/state array, and issues any required bus operations (writeback, read, RFO, invalidate). It then presents presentState/command/snoopResponse to the MESI block and writes the returned resultState back into the array. It also keeps hit/miss counters.

Parameters:
ADDR_W, 32, request address width
INDEX_BITS, 4, line index bits (NUM_LINES = 2**INDEX_BITS)
OFFSET_BITS, 6, byte offset bits; tag = ADDR_W-INDEX_BITS-OFFSET_BITS
CNT_W, 32, hit/miss counter width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd  in  4  command code: 0 rd, 1 wr, 2 inst rd, 3 snp inv, 4 snp rd, 5 snp wr, 6 snp RFO, 8 clear, 9 print
addr  in  ADDR_W  request address
bus_req  out  1  bus operation request
bus_op  out  2  0 READ, 1 WRITEBACK, 2 INVALIDATE, 3 RFO
bus_addr  out  ADDR_W  line address, offset bits zero
bus_ack  in  1  bus completion
bus_snoop_resp  in  2  other caches' response, sampled with bus_ack (0 NoHIT, 1 HIT, 2 HITM)
snoop_resp_out  out  2  this cache's response to snoop commands, valid with done
mesi_present_state  out  2  to MESI block (M=0 E=1 S=2 I=3)
mesi_command  out  4  to MESI block
mesi_snoop_resp  out  2  to MESI block
mesi_result_state  in  2  from MESI block, combinational
done  out  1  one-cycle completion pulse
hit  out  1  lookup hit, valid with done
hit_count  out  CNT_W  local-access hits
miss_count  out  CNT_W  local-access misses

Behaviour:
- FSM states: IDLE, LOOKUP, WB, BUS, UPDATE.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd/addr and go to LOOKUP.
- LOOKUP (1 cycle): read tag/state at index. Line hit = tag match && state!=I.
- Local rd/inst rd:
  - hit -> UPDATE.
  - miss -> READ.
- Local wr:
  - hit in M/E -> UPDATE.
  - hit in S -> INVALIDATE.
  - miss -> RFO.
- Local miss with victim in M: WRITEBACK to {victim tag, index, 0} first (WB state), then the fill op.
- Local miss: mesi_present_state=I, mesi_snoop_resp=bus_snoop_resp captured at ack of the fill/invalidate op. Local hit with no bus op: mesi_snoop_resp=NoHIT.
- Snoop cmds 3-6: own response is HITM if hit in M, HIT if hit in E/S, else NoHIT. This drives snoop_resp_out and mesi_snoop_resp.
  - HITM on cmd 4/5/6 -> WRITEBACK of the line before UPDATE.
  - Snoop miss: no array write.
- clear: all lines -> I in the UPDATE cycle. print and undefined codes: no array change. All three set hit=0, counters unchanged.
- Bus handshake: bus_req/op/addr held stable from entry to WB/BUS until the cycle bus_ack=1. bus_req is low the following cycle. No bus_req while idle.
- UPDATE (1 cycle): done=1. state[index] <= mesi_result_state. On a local miss, tag[index] <= new tag. Return to IDLE.
- Latency: a hit with no bus op has done two cycles after the accept edge. Each bus op adds wait cycles until ack plus 1.
- Counters: increment on done for cmds 0-2 only, wrap modulo 2**CNT_W.
- Reset (any state, including mid-bus-op): FSM=IDLE, all lines I, tags 0, bus_req=0, done=0, hit=0, snoop_resp_out=0, counters=0, mesi outputs = {I, cmd 8, NoHIT}.
- Back-to-back: a new cmd is accepted the cycle after done. An update to the same index is visible to the next lookup.

Decomposition:
- Shared package l2_cache_pkg holds the MESI state encodings, command codes, snoop response codes, bus_op codes and an fsm state typedef. cache_Mesi uses the same package.
- One sub-module, l2_line_array: tag+state register array with 1 read port, 1 write port and an invalidate-all input.

Test Plan:
- Reset, rd 0x0000_1040 with bus_snoop_resp=NoHIT -> one READ to 0x0000_1040, line E, miss_count=1, hit=0.
- Rd same address again -> no bus_req, done 2 cycles after accept, hit=1, hit_count=1, state stays E.
- Wr to an S line (prior rd with resp HIT) -> INVALIDATE issued, state M.
- Line M, rd 0x0002_1040 (same index, different tag) -> WRITEBACK to 0x0000_1040, then READ to 0x0002_1040, tag updated.
- Line M, snoop rd on the same address -> snoop_resp_out=HITM, WRITEBACK issued, state S.
- Assert rst while bus_req is waiting for ack -> bus_req=0 next cycle, clear-all then a rd of any address misses, counters 0.
